sb_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one sideband serializer among NUM_REQ message sources (link-training FSM, register-access engine, error reporting).
- Accepts one WIDTH-bit message at a time and hands it to the serializer over a valid/ready handshake.
- Waits for the serializer's completion pulse, then enforces a GAP_CYCLES idle gap before issuing the next grant.
- Sits between the sideband message sources and the serializer, mirroring the receive-side deserializer.

---
 rtl/sb_tx_scheduler_if.sv | 28 ++
 rtl/sb_tx_scheduler.sv | 141 ++++++++++++++
 tb/tb_sb_tx_scheduler.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_tx_scheduler_if.sv
// Bundles the requester-side and serializer-side signals of the sideband
// transmit scheduler. The scheduler uses the master modport; the environment uses slave.
interface sb_tx_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 128,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         ser_data;
    logic                     ser_valid;
    logic                     ser_ready;
    logic                     ser_done;
    logic [ID_W-1:0]          grant_id;
    logic                     busy;
    logic [15:0]              sent_count;

    modport master (
        input  req_valid, req_data, ser_ready, ser_done,
        output req_ready, ser_data, ser_valid, grant_id, busy, sent_count
    );

    modport slave (
        output req_valid, req_data, ser_ready, ser_done,
        input  req_ready, ser_data, ser_valid, grant_id, busy, sent_count
    );
endinterface

// File: rtl/sb_tx_scheduler.sv
// Round-robin scheduler sharing one sideband serializer among NUM_REQ sources,
// with a post-completion idle gap before the next grant.
module sb_tx_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int WIDTH      = 128,
    parameter int GAP_CYCLES = 32,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    sb_tx_scheduler_if.master  bus
);

    localparam int unsigned NREQ  = NUM_REQ;
    localparam int          CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_cnt_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic             found;
    logic             accept;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [WIDTH-1:0] ser_data_q;
    logic [ID_W-1:0]  grant_id_q;
    logic [15:0]      sent_count_q;

    // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first valid requester wins.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] idx_id;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_id = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_id = ID_W'(idx);
            if (!found && bus.req_valid[idx_id]) begin
                found  = 1'b1;
                winner = idx_id;
            end
        end
    end

    assign accept = (state == IDLE) && found;

    always_comb begin
        req_ready_c = '0;
        if (accept) begin
            req_ready_c[winner] = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.ser_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.ser_done) begin
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_cnt_nxt = GAP_LOAD;
                        state_nxt   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_data_q   <= '0;
            grant_id_q   <= '0;
            rr_ptr       <= '0;
            sent_count_q <= '0;
        end else begin
            if (accept) begin
                ser_data_q <= bus.req_data[winner*WIDTH +: WIDTH];
                grant_id_q <= winner;
                rr_ptr     <= (winner == LAST_ID) ? '0 : winner + 1'b1;
            end
            if ((state == WAIT_DONE) && bus.ser_done) begin
                sent_count_q <= sent_count_q + 16'd1;
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.ser_data   = ser_data_q;
    assign bus.ser_valid  = (state == SEND);
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = (state != IDLE);
    assign bus.sent_count = sent_count_q;

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Scoreboard bench for sb_tx_scheduler: a default build (GAP_CYCLES=32) and a
// zero-gap build share clock and reset.
module tb_sb_tx_scheduler;

    localparam int NR  = 3;
    localparam int W   = 128;
    localparam int IW  = 2;
    localparam int GAP = 32;

    typedef struct {
        logic [W-1:0]  data;
        logic [IW-1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t        sb[$];
    int          tests = 0;
    int          failed = 0;
    int          onehot_err = 0;
    int          model_ptr = 0;
    int          exp_sent = 0;
    logic [W-1:0] slot [NR];

    always #5 clk = ~clk;

    sb_tx_scheduler_if #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) bus ();
    sb_tx_scheduler_if #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW)) bus_z ();

    sb_tx_scheduler #(.NUM_REQ(NR), .WIDTH(W), .GAP_CYCLES(GAP), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    sb_tx_scheduler #(.NUM_REQ(NR), .WIDTH(W), .GAP_CYCLES(0), .ID_W(IW)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z.master)
    );

    always @(negedge clk) begin
        if (!rst && (!$onehot0(bus.req_ready) || !$onehot0(bus_z.req_ready))) begin
            onehot_err++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (ptr + k) % NR;
            if (((v >> idx) & 3'b001) != 3'b000) return idx;
        end
        return 0;
    endfunction

    task automatic push_expected(input logic [NR-1:0] v);
        int   w;
        exp_t e;
        w = model_pick(v, model_ptr);
        e.data = slot[w];
        e.id = IW'(w);
        sb.push_back(e);
        model_ptr = (w + 1) % NR;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.ser_ready = 1'b0;
        bus.ser_done = 1'b0;
        bus.req_data = {slot[2], slot[1], slot[0]};
        bus_z.req_valid = '0;
        bus_z.ser_ready = 1'b0;
        bus_z.ser_done = 1'b0;
        bus_z.req_data = {slot[2], slot[1], slot[0]};
        repeat (2) tick();
        rst = 1'b0;
        model_ptr = 0;
        exp_sent = 0;
        sb.delete();
    endtask

    // Serializer model: waits for ser_valid, accepts, pulses done after
    // done_delay cycles, then waits for the scheduler to return to IDLE.
    task automatic serve(input int done_delay, output logic [W-1:0] d,
                         output logic [IW-1:0] id, output bit to);
        int n;
        to = 1'b0;
        d = '0;
        id = '0;
        n = 0;
        while (bus.ser_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (bus.ser_valid !== 1'b1) begin
            to = 1'b1;
            return;
        end
        d = bus.ser_data;
        id = bus.grant_id;
        bus.ser_ready = 1'b1;
        tick();
        bus.ser_ready = 1'b0;
        repeat (done_delay - 1) tick();
        bus.ser_done = 1'b1;
        exp_sent++;
        tick();
        bus.ser_done = 1'b0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (bus.busy !== 1'b0) to = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (bus.ser_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 3'b000) begin
            failed++;
            $display("FAIL reset_ctrl: ser_valid=%b busy=%b req_ready=%b, required 0 0 000",
                     bus.ser_valid, bus.busy, bus.req_ready);
        end
        tests++;
        if (bus.sent_count !== 16'd0 || bus.grant_id !== 2'd0 || bus.ser_data !== '0) begin
            failed++;
            $display("FAIL reset_data: sent_count=%0d grant_id=%0d ser_data=%h, required zeros",
                     bus.sent_count, bus.grant_id, bus.ser_data);
        end
        tests++;
        if (bus_z.busy !== 1'b0 || bus_z.sent_count !== 16'd0) begin
            failed++;
            $display("FAIL reset_zgap: busy=%b sent_count=%0d, required 0 0",
                     bus_z.busy, bus_z.sent_count);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   bad;
        int   n;
        logic [W-1:0]  d;
        logic [IW-1:0] id;
        bit   to;
        bus.req_valid = 3'b001;
        push_expected(3'b001);
        #1;
        tests++;
        if (bus.req_ready !== 3'b001) begin
            failed++;
            $display("FAIL single_ready: req_ready=%b, required 001", bus.req_ready);
        end
        tick();
        bus.req_valid = 3'b000;
        e = sb.pop_front();
        tests++;
        if (bus.req_ready !== 3'b000 || bus.ser_valid !== 1'b1 ||
            bus.ser_data !== e.data || bus.grant_id !== e.id) begin
            failed++;
            $display("FAIL single_send: ready=%b valid=%b id=%0d data=%h, required 000 1 %0d %h",
                     bus.req_ready, bus.ser_valid, bus.grant_id, bus.ser_data, e.id, e.data);
        end
        bad = 0;
        repeat (5) begin
            tick();
            if (bus.ser_valid !== 1'b1 || bus.ser_data !== e.data || bus.grant_id !== e.id) bad++;
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL single_hold: %0d unstable cycles, required 0", bad);
        end
        bus.ser_ready = 1'b1;
        tick();
        bus.ser_ready = 1'b0;
        tests++;
        if (bus.ser_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failed++;
            $display("FAIL single_wait: ser_valid=%b busy=%b, required 0 1", bus.ser_valid, bus.busy);
        end
        repeat (129) tick();
        bus.ser_done = 1'b1;
        exp_sent++;
        tick();
        bus.ser_done = 1'b0;
        tests++;
        if (bus.sent_count !== 16'(exp_sent)) begin
            failed++;
            $display("FAIL single_count: sent_count=%0d, required %0d", bus.sent_count, exp_sent);
        end
        // A request raised during the gap must wait for IDLE.
        bus.req_valid = 3'b010;
        n = 0;
        bad = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (bus.req_ready !== 3'b000) bad++;
            tick();
            n++;
        end
        tests++;
        if (n != GAP || bad != 0) begin
            failed++;
            $display("FAIL single_gap: gap=%0d ready_in_gap=%0d, required %0d 0", n, bad, GAP);
        end
        tests++;
        if (bus.req_ready !== 3'b010 || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL single_idle_ready: req_ready=%b busy=%b, required 010 0",
                     bus.req_ready, bus.busy);
        end
        push_expected(3'b010);
        tick();
        bus.req_valid = 3'b000;
        serve(4, d, id, to);
        e = sb.pop_front();
        tests++;
        if (to || d !== e.data || id !== e.id) begin
            failed++;
            $display("FAIL single_second: id=%0d data=%h timeout=%0d, required id=%0d data=%h",
                     id, d, to, e.id, e.data);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   err0;
        logic [W-1:0]  d;
        logic [IW-1:0] id;
        bit   to;
        apply_reset();
        err0 = onehot_err;
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            push_expected(3'b111);
            serve(4, d, id, to);
            if (k == 5) bus.req_valid = 3'b000;
            e = sb.pop_front();
            tests++;
            if (to || d !== e.data || id !== e.id) begin
                failed++;
                $display("FAIL rr_grant%0d: id=%0d data=%h timeout=%0d, required id=%0d data=%h",
                         k, id, d, to, e.id, e.data);
            end
        end
        tests++;
        if (onehot_err != err0) begin
            failed++;
            $display("FAIL rr_onehot: %0d non-one-hot req_ready cycles, required 0",
                     onehot_err - err0);
        end
        tests++;
        if (bus.sent_count !== 16'(exp_sent)) begin
            failed++;
            $display("FAIL rr_count: sent_count=%0d, required %0d", bus.sent_count, exp_sent);
        end
    endtask

    task automatic test_pointer_wrap();
        exp_t e;
        logic [W-1:0]  d;
        logic [IW-1:0] id;
        bit   to;
        bus.req_valid = 3'b011;
        for (int k = 0; k < 2; k++) begin
            push_expected(3'b011);
            serve(3, d, id, to);
            if (k == 1) bus.req_valid = 3'b000;
            e = sb.pop_front();
            tests++;
            if (to || d !== e.data || id !== e.id) begin
                failed++;
                $display("FAIL wrap_grant%0d: id=%0d data=%h timeout=%0d, required id=%0d data=%h",
                         k, id, d, to, e.id, e.data);
            end
        end
    endtask

    task automatic test_stray_done();
        exp_t e;
        int   n;
        logic [W-1:0]  d;
        logic [IW-1:0] id;
        bus.ser_done = 1'b1;
        tick();
        bus.ser_done = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.sent_count !== 16'(exp_sent)) begin
            failed++;
            $display("FAIL stray_idle: busy=%b sent_count=%0d, required 0 %0d",
                     bus.busy, bus.sent_count, exp_sent);
        end
        bus.req_valid = 3'b100;
        push_expected(3'b100);
        tick();
        bus.req_valid = 3'b000;
        d = bus.ser_data;
        id = bus.grant_id;
        bus.ser_done = 1'b1;
        tick();
        bus.ser_done = 1'b0;
        tests++;
        if (bus.ser_valid !== 1'b1 || bus.sent_count !== 16'(exp_sent)) begin
            failed++;
            $display("FAIL stray_send: ser_valid=%b sent_count=%0d, required 1 %0d",
                     bus.ser_valid, bus.sent_count, exp_sent);
        end
        e = sb.pop_front();
        tests++;
        if (d !== e.data || id !== e.id) begin
            failed++;
            $display("FAIL stray_grant: id=%0d data=%h, required id=%0d data=%h", id, d, e.id, e.data);
        end
        bus.ser_ready = 1'b1;
        tick();
        bus.ser_ready = 1'b0;
        bus.ser_done = 1'b1;
        exp_sent++;
        tick();
        bus.ser_done = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            bus.ser_done = (n == 3 || n == 10) ? 1'b1 : 1'b0;
            tick();
            n++;
        end
        bus.ser_done = 1'b0;
        tests++;
        if (n != GAP || bus.sent_count !== 16'(exp_sent)) begin
            failed++;
            $display("FAIL stray_gap: gap=%0d sent_count=%0d, required %0d %0d",
                     n, bus.sent_count, GAP, exp_sent);
        end
    endtask

    task automatic test_zero_gap();
        apply_reset();
        bus_z.req_valid = 3'b001;
        tick();
        tests++;
        if (bus_z.ser_valid !== 1'b1 || bus_z.grant_id !== 2'd0 || bus_z.ser_data !== slot[0]) begin
            failed++;
            $display("FAIL zgap_send: valid=%b id=%0d data=%h, required 1 0 %h",
                     bus_z.ser_valid, bus_z.grant_id, bus_z.ser_data, slot[0]);
        end
        bus_z.ser_ready = 1'b1;
        tick();
        bus_z.ser_ready = 1'b0;
        tick();
        bus_z.ser_done = 1'b1;
        tick();
        bus_z.ser_done = 1'b0;
        tests++;
        if (bus_z.req_ready !== 3'b001 || bus_z.busy !== 1'b0 || bus_z.sent_count !== 16'd1) begin
            failed++;
            $display("FAIL zgap_ready: req_ready=%b busy=%b sent_count=%0d, required 001 0 1",
                     bus_z.req_ready, bus_z.busy, bus_z.sent_count);
        end
        bus_z.req_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [W-1:0]  d;
        logic [IW-1:0] id;
        bit   to;
        apply_reset();
        bus.req_valid = 3'b100;
        for (int k = 0; k < 5; k++) begin
            push_expected(3'b100);
            serve(3, d, id, to);
            e = sb.pop_front();
            tests++;
            if (to || d !== e.data || id !== e.id) begin
                failed++;
                $display("FAIL mid_grant%0d: id=%0d data=%h timeout=%0d, required id=%0d data=%h",
                         k, id, d, to, e.id, e.data);
            end
        end
        tick();
        bus.req_valid = 3'b000;
        bus.ser_ready = 1'b1;
        tick();
        bus.ser_ready = 1'b0;
        tests++;
        if (bus.sent_count !== 16'd5 || bus.busy !== 1'b1 || bus.grant_id !== 2'd2) begin
            failed++;
            $display("FAIL mid_pre: sent_count=%0d busy=%b id=%0d, required 5 1 2",
                     bus.sent_count, bus.busy, bus.grant_id);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.ser_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sent_count !== 16'd0 ||
            bus.grant_id !== 2'd0 || bus.req_ready !== 3'b000) begin
            failed++;
            $display("FAIL mid_async: valid=%b busy=%b sent=%0d id=%0d ready=%b, required 0 0 0 0 000",
                     bus.ser_valid, bus.busy, bus.sent_count, bus.grant_id, bus.req_ready);
        end
        tick();
        rst = 1'b0;
        model_ptr = 0;
        exp_sent = 0;
        bus.req_valid = 3'b111;
        push_expected(3'b111);
        tick();
        bus.req_valid = 3'b000;
        serve(3, d, id, to);
        e = sb.pop_front();
        tests++;
        if (to || d !== e.data || id !== e.id || bus.sent_count !== 16'd1) begin
            failed++;
            $display("FAIL mid_after: id=%0d data=%h timeout=%0d sent=%0d, required id=%0d data=%h sent=1",
                     id, d, to, bus.sent_count, e.id, e.data);
        end
    endtask

    initial begin
        slot[0] = {16{8'hA5}};
        slot[1] = {16{8'h3C}};
        slot[2] = {16{8'hC3}};
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_stray_done();
        test_zero_gap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
